// File: rtl/dma_chan_sched.sv
// dma_chan_sched
//   Transfer engine and round-robin scheduler behind the 4-channel DMA register
//   file. An armed channel with ch_start high is granted the engine. The engine
//   copies DATA_W-bit words from src to dest, one read beat followed by one
//   write beat, over a single memory master port. Per-channel busy, done and
//   err are reported back to the register block.
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   ch_start/src/dest/size         per-channel request and transfer descriptor
//   ch_busy                        channel currently owns the engine
//   ch_done, ch_err                one-cycle completion / failure pulses
//   mem_addr/wdata/re/we           master request, held until mem_ack
//   mem_rdata/ack/err              memory response; mem_err qualified by mem_ack
module dma_chan_sched #(
   parameter int unsigned NCHAN  = 4,
   parameter int unsigned ADDR_W = 48,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned SIZE_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NCHAN-1:0]        ch_start,
   input  logic [NCHAN*ADDR_W-1:0] ch_src,
   input  logic [NCHAN*ADDR_W-1:0] ch_dest,
   input  logic [NCHAN*SIZE_W-1:0] ch_size,
   output logic [NCHAN-1:0]        ch_busy,
   output logic [NCHAN-1:0]        ch_done,
   output logic [NCHAN-1:0]        ch_err,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   output logic                    mem_re,
   output logic                    mem_we,
   input  logic [DATA_W-1:0]       mem_rdata,
   input  logic                    mem_ack,
   input  logic                    mem_err
);

   localparam int unsigned PTR_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StFin} state_e;

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]  ch_q, ch_d;
   logic [NCHAN-1:0]  arm_q, arm_d;
   logic [NCHAN-1:0]  done_q, done_d;
   logic [NCHAN-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic [SIZE_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              fail_q, fail_d;

   // Unpacked views of the flattened descriptor buses
   logic [ADDR_W-1:0] src_arr  [NCHAN];
   logic [ADDR_W-1:0] dest_arr [NCHAN];
   logic [SIZE_W-1:0] size_arr [NCHAN];

   always_comb begin
      for (int unsigned i = 0; i < NCHAN; i++) begin
         src_arr[i]  = ch_src[i*ADDR_W +: ADDR_W];
         dest_arr[i] = ch_dest[i*ADDR_W +: ADDR_W];
         size_arr[i] = ch_size[i*SIZE_W +: SIZE_W];
      end
   end

   // Round-robin search from rr_ptr, ascending with wrap
   logic [NCHAN-1:0] elig;
   logic             grant_vld;
   logic [PTR_W-1:0] grant_ch;
   logic [PTR_W-1:0] cand;

   always_comb begin
      elig      = ch_start & arm_q;
      grant_vld = 1'b0;
      grant_ch  = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NCHAN; k++) begin
         cand = PTR_W'((32'(rr_ptr_q) + k) % NCHAN);
         if (!grant_vld && elig[cand]) begin
            grant_vld = 1'b1;
            grant_ch  = cand;
         end
      end
   end

   // Owner dropped its start: honoured at the next beat boundary. Requests are
   // issued on entry to RD/WR, so a beat is always in flight and the boundary
   // is its ack.
   logic abort;
   assign abort = !ch_start[ch_q];

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      ch_d      = ch_q;
      // Arm re-sets on any cycle the request is low
      arm_d     = arm_q | ~ch_start;
      done_d    = '0;
      err_d     = '0;
      src_d     = src_q;
      dest_d    = dest_q;
      rem_d     = rem_q;
      data_d    = data_q;
      fail_d    = fail_q;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      unique case (state_q)
         StIdle: begin
            if (grant_vld) begin
               arm_d[grant_ch] = 1'b0;
               ch_d     = grant_ch;
               rr_ptr_d = (grant_ch == PTR_W'(NCHAN - 1)) ? '0 : grant_ch + 1'b1;
               src_d    = src_arr[grant_ch];
               dest_d   = dest_arr[grant_ch];
               rem_d    = size_arr[grant_ch];
               fail_d   = 1'b0;
               state_d  = (size_arr[grant_ch] == '0) ? StFin : StRd;
            end
         end
         StRd: begin
            mem_re   = 1'b1;
            mem_addr = src_q;
            if (mem_ack) begin
               if (mem_err || abort) begin
                  fail_d  = 1'b1;
                  state_d = StFin;
               end else begin
                  data_d  = mem_rdata;
                  state_d = StWr;
               end
            end
         end
         StWr: begin
            mem_we    = 1'b1;
            mem_addr  = dest_q;
            mem_wdata = data_q;
            if (mem_ack) begin
               if (mem_err) begin
                  fail_d  = 1'b1;
                  state_d = StFin;
               end else begin
                  src_d  = src_q + STRIDE;
                  dest_d = dest_q + STRIDE;
                  rem_d  = rem_q - 1'b1;
                  if (abort) begin
                     fail_d  = 1'b1;
                     state_d = StFin;
                  end else if (rem_q == SIZE_W'(1)) begin
                     state_d = StFin;
                  end else begin
                     state_d = StRd;
                  end
               end
            end
         end
         StFin: begin
            // Pulses are registered, so they appear as busy drops
            done_d[ch_q] = !fail_q;
            err_d[ch_q]  = fail_q;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         ch_q     <= '0;
         arm_q    <= '1;
         done_q   <= '0;
         err_q    <= '0;
         src_q    <= '0;
         dest_q   <= '0;
         rem_q    <= '0;
         data_q   <= '0;
         fail_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         ch_q     <= ch_d;
         arm_q    <= arm_d;
         done_q   <= done_d;
         err_q    <= err_d;
         src_q    <= src_d;
         dest_q   <= dest_d;
         rem_q    <= rem_d;
         data_q   <= data_d;
         fail_q   <= fail_d;
      end
   end

   always_comb begin
      ch_busy = '0;
      if (state_q != StIdle) ch_busy[ch_q] = 1'b1;
   end

   assign ch_done = done_q;
   assign ch_err  = err_q;

endmodule

// File: tb/tb_dma_chan_sched.sv
// Testbench for dma_chan_sched: memory responder with random wait states, a
// negedge monitor that logs beats/grants/pulses, and a transaction-level model
// (round-robin order plus expected beat list per transfer).
module tb_dma_chan_sched;
   localparam int NCHAN = 4;
   localparam int ADDR_W = 48;
   localparam int DATA_W = 64;
   localparam int SIZE_W = 16;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } beat_t;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NCHAN-1:0]        ch_start;
   logic [NCHAN*ADDR_W-1:0] ch_src, ch_dest;
   logic [NCHAN*SIZE_W-1:0] ch_size;
   logic [NCHAN-1:0]        ch_busy, ch_done, ch_err;
   logic [ADDR_W-1:0]       mem_addr;
   logic [DATA_W-1:0]       mem_wdata, mem_rdata;
   logic                    mem_re, mem_we, mem_ack, mem_err;

   dma_chan_sched dut (
      .clk(clk), .rst_n(rst_n), .ch_start(ch_start), .ch_src(ch_src), .ch_dest(ch_dest),
      .ch_size(ch_size), .ch_busy(ch_busy), .ch_done(ch_done), .ch_err(ch_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- memory responder ----------------
   int                min_lat = 0, max_lat = 0;
   int                lat = 0, wcnt = 0;
   logic              err_en = 1'b0;
   logic [ADDR_W-1:0] err_addr = '0;

   function automatic logic [DATA_W-1:0] fdata(input logic [ADDR_W-1:0] a);
      return {a[31:0] ^ 32'hDEAD_BEEF, 16'h5A5A, a[47:32]};
   endfunction

   assign mem_ack   = (mem_re || mem_we) && (wcnt >= lat);
   assign mem_err   = err_en && mem_re && (mem_addr == err_addr);
   assign mem_rdata = fdata(mem_addr);

   always @(posedge clk) begin
      if (mem_ack) begin
         wcnt <= 0;
         lat  <= int'($urandom_range(max_lat, min_lat));
      end else if (mem_re || mem_we) begin
         wcnt <= wcnt + 1;
      end else begin
         wcnt <= 0;
         lat  <= int'($urandom_range(max_lat, min_lat));
      end
   end

   // ---------------- monitor ----------------
   beat_t      obs_q[$];
   int         grant_q[$];
   int         busy_cyc[NCHAN] = '{default: 0};
   int         done_cnt[NCHAN] = '{default: 0};
   int         err_cnt[NCHAN]  = '{default: 0};
   int         req_cycles = 0, overlap = 0;
   logic [3:0] busy_prev = '0;

   always @(negedge clk) begin
      if (mem_ack) obs_q.push_back({mem_we, mem_addr, (mem_we ? mem_wdata : mem_rdata)});
      if (mem_re || mem_we) req_cycles <= req_cycles + 1;
      if (mem_re && mem_we) overlap <= overlap + 1;
      for (int i = 0; i < NCHAN; i++) begin
         if (ch_busy[i] && !busy_prev[i]) grant_q.push_back(i);
         if (ch_busy[i]) busy_cyc[i] <= busy_cyc[i] + 1;
         if (ch_done[i]) done_cnt[i] <= done_cnt[i] + 1;
         if (ch_err[i]) err_cnt[i] <= err_cnt[i] + 1;
      end
      busy_prev <= ch_busy;
   end

   // ---------------- reference model ----------------
   logic [ADDR_W-1:0] t_src[NCHAN], t_dst[NCHAN];
   int                t_size[NCHAN];
   beat_t             exp_q[$];
   int                ord_q[$];
   int                tb_ptr = 0;

   task automatic set_ch(input int c, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                         input int n);
      t_src[c] = s;
      t_dst[c] = d;
      t_size[c] = n;
      ch_src[c*ADDR_W +: ADDR_W]  = s;
      ch_dest[c*ADDR_W +: ADDR_W] = d;
      ch_size[c*SIZE_W +: SIZE_W] = SIZE_W'(n);
   endtask

   // Expected beats for one transfer: word k is read at src+8k, written to dest+8k
   task automatic add_exp(input int c, input int limit);
      logic [ADDR_W-1:0] a, w;
      for (int k = 0; k < t_size[c]; k++) begin
         a = t_src[c] + ADDR_W'(8 * k);
         w = t_dst[c] + ADDR_W'(8 * k);
         if (limit >= 0 && exp_q.size() >= limit) break;
         exp_q.push_back({1'b0, a, fdata(a)});
         if (limit >= 0 && exp_q.size() >= limit) break;
         exp_q.push_back({1'b1, w, fdata(a)});
      end
   endtask

   // Service order of a set of simultaneous requests; advances the model pointer
   task automatic rr_model(input logic [3:0] mask);
      int c;
      ord_q.delete();
      for (int k = 0; k < NCHAN; k++) begin
         c = (tb_ptr + k) % NCHAN;
         if (mask[c]) ord_q.push_back(c);
      end
      if (ord_q.size() > 0) tb_ptr = (ord_q[ord_q.size()-1] + 1) % NCHAN;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Bounded wait for n done/err pulses; expiry counts as a failure
   task automatic wait_pulses(input int n, input int budget, input string tag);
      int seen = 0;
      int cyc = 0;
      while (seen < n && cyc < budget) begin
         step();
         cyc++;
         seen += $countones(ch_done | ch_err);
      end
      checks++;
      if (seen != n) begin
         errors++;
         $display("FAIL %s_timeout: %0d completions seen, required %0d", tag, seen, n);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      ch_start = '0; ch_src = '0; ch_dest = '0; ch_size = '0;
      step(); step();
      checks += 4;
      if (ch_busy !== 4'h0 || ch_done !== 4'h0 || ch_err !== 4'h0) begin
         errors++;
         $display("FAIL reset_status: busy=%h done=%h err=%h, required 0", ch_busy, ch_done, ch_err);
      end
      if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
         errors++; $display("FAIL reset_req: re=%b we=%b, required 0", mem_re, mem_we);
      end
      if (mem_addr !== '0) begin
         errors++; $display("FAIL reset_addr: got %h, required 0", mem_addr);
      end
      if (mem_wdata !== '0) begin
         errors++; $display("FAIL reset_wdata: got %h, required 0", mem_wdata);
      end
      rst_n = 1'b1;
      tb_ptr = 0;
      step();
   endtask

   task automatic test_basic();
      int ob = obs_q.size();
      int bc = busy_cyc[0], dc = done_cnt[0], ec = err_cnt[0];
      min_lat = 0; max_lat = 0;
      set_ch(0, 48'h1000, 48'h2000, 3);
      exp_q.delete(); add_exp(0, -1);
      ch_start[0] = 1'b1;
      step();
      checks++;
      if (mem_re !== 1'b1 || mem_addr !== 48'h1000) begin
         errors++; $display("FAIL basic_latency: re=%b addr=%h, required re=1 addr=1000", mem_re, mem_addr);
      end
      wait_pulses(1, 50, "basic");
      ch_start[0] = 1'b0;
      step();
      tb_ptr = 1;
      checks++;
      if (obs_q.size() - ob != exp_q.size()) begin
         errors++; $display("FAIL basic_beats: got %0d beats, required %0d", obs_q.size() - ob, exp_q.size());
      end
      foreach (exp_q[k]) if (ob + k < obs_q.size()) begin
         checks++;
         if (obs_q[ob+k] !== exp_q[k]) begin
            errors++;
            $display("FAIL basic_beat%0d: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h", k,
                     obs_q[ob+k].we, obs_q[ob+k].addr, obs_q[ob+k].data, exp_q[k].we, exp_q[k].addr, exp_q[k].data);
         end
      end
      checks += 2;
      if (done_cnt[0] - dc != 1 || err_cnt[0] - ec != 0) begin
         errors++; $display("FAIL basic_pulses: done=%0d err=%0d, required 1 and 0", done_cnt[0] - dc, err_cnt[0] - ec);
      end
      if (busy_cyc[0] - bc != 7) begin
         errors++; $display("FAIL basic_busy_len: got %0d cycles, required 7", busy_cyc[0] - bc);
      end
   endtask

   task automatic test_rr_order();
      int ob, gb;
      rst_n = 1'b0; step(); rst_n = 1'b1; tb_ptr = 0;
      min_lat = 0; max_lat = 1;
      for (int c = 0; c < NCHAN; c++) set_ch(c, 48'h10_0000 + 48'(c * 'h100), 48'h20_0000 + 48'(c * 'h100), 1);
      for (int pass = 0; pass < 2; pass++) begin
         ob = obs_q.size(); gb = grant_q.size();
         rr_model(pass == 0 ? 4'hF : 4'hA);
         exp_q.delete();
         foreach (ord_q[k]) add_exp(ord_q[k], -1);
         if (pass == 0) begin
            ch_start = 4'hF;
            wait_pulses(4, 100, "rr_all");
         end else begin
            ch_start[1] = 1'b0; ch_start[3] = 1'b0;
            step();
            ch_start[1] = 1'b1; ch_start[3] = 1'b1;
            wait_pulses(2, 100, "rr_rearm");
         end
         step();
         checks++;
         if (grant_q.size() - gb != ord_q.size()) begin
            errors++; $display("FAIL rr_grant_count: got %0d grants, required %0d", grant_q.size() - gb, ord_q.size());
         end
         foreach (ord_q[k]) if (gb + k < grant_q.size()) begin
            checks++;
            if (grant_q[gb+k] != ord_q[k]) begin
               errors++; $display("FAIL rr_grant%0d: got ch%0d, required ch%0d", k, grant_q[gb+k], ord_q[k]);
            end
         end
         foreach (exp_q[k]) if (ob + k < obs_q.size()) begin
            checks++;
            if (obs_q[ob+k] !== exp_q[k]) begin
               errors++; $display("FAIL rr_beat%0d: got addr=%h we=%b, required addr=%h we=%b", k,
                                  obs_q[ob+k].addr, obs_q[ob+k].we, exp_q[k].addr, exp_q[k].we);
            end
         end
      end
      ch_start = '0;
      step();
   endtask

   task automatic test_zero_size();
      int rq = req_cycles, ob = obs_q.size();
      set_ch(2, 48'h7000, 48'h7800, 0);
      ch_start[2] = 1'b1;
      step();
      checks++;
      if (ch_busy !== 4'b0100 || ch_done !== 4'b0000) begin
         errors++; $display("FAIL zero_t1: busy=%b done=%b, required busy=0100 done=0000", ch_busy, ch_done);
      end
      step();
      checks++;
      if (ch_done !== 4'b0100) begin
         errors++; $display("FAIL zero_done_t2: done=%b, required 0100", ch_done);
      end
      step(); step();
      checks++;
      if (req_cycles != rq || obs_q.size() != ob) begin
         errors++; $display("FAIL zero_no_bus: %0d request cycles, required 0", req_cycles - rq);
      end
      ch_start[2] = 1'b0;
      tb_ptr = 3;
      step();
   endtask

   task automatic test_bus_err();
      int ob = obs_q.size(), dc = done_cnt[0], ec = err_cnt[0];
      min_lat = 0; max_lat = 2;
      set_ch(0, 48'h4000, 48'h8000, 4);
      err_en = 1'b1; err_addr = 48'h4008;
      exp_q.delete(); add_exp(0, 3);
      ch_start[0] = 1'b1;
      wait_pulses(1, 60, "buserr");
      checks++;
      if (ch_busy !== 4'h0) begin
         errors++; $display("FAIL buserr_busy: busy=%b, required 0000", ch_busy);
      end
      step();
      ch_start[0] = 1'b0; err_en = 1'b0; tb_ptr = 1;
      checks += 2;
      if (err_cnt[0] - ec != 1 || done_cnt[0] - dc != 0) begin
         errors++; $display("FAIL buserr_pulses: err=%0d done=%0d, required 1 and 0", err_cnt[0] - ec, done_cnt[0] - dc);
      end
      if (obs_q.size() - ob != 3) begin
         errors++; $display("FAIL buserr_beats: got %0d beats, required 3", obs_q.size() - ob);
      end
      foreach (exp_q[k]) if (ob + k < obs_q.size()) begin
         checks++;
         if (obs_q[ob+k].we !== exp_q[k].we || obs_q[ob+k].addr !== exp_q[k].addr) begin
            errors++; $display("FAIL buserr_beat%0d: got addr=%h we=%b, required addr=%h we=%b", k,
                               obs_q[ob+k].addr, obs_q[ob+k].we, exp_q[k].addr, exp_q[k].we);
         end
      end
      step();
   endtask

   task automatic test_abort();
      int ob = obs_q.size(), dc = done_cnt[3], ec = err_cnt[3], cyc = 0;
      min_lat = 2; max_lat = 2;
      set_ch(3, 48'h9_0000, 48'hA_0000, 8);
      ch_start[3] = 1'b1;
      while (!(obs_q.size() - ob >= 2 && mem_re) && cyc < 40) begin
         step(); cyc++;
      end
      ch_start[3] = 1'b0;
      wait_pulses(1, 40, "abort");
      step();
      tb_ptr = 0;
      checks += 2;
      if (err_cnt[3] - ec != 1 || done_cnt[3] - dc != 0) begin
         errors++; $display("FAIL abort_pulses: err=%0d done=%0d, required 1 and 0", err_cnt[3] - ec, done_cnt[3] - dc);
      end
      if (obs_q.size() - ob != 3) begin
         errors++; $display("FAIL abort_beats: got %0d beats, required 3", obs_q.size() - ob);
      end
   endtask

   task automatic test_reset_mid();
      int ob, cyc = 0;
      min_lat = 3; max_lat = 3;
      set_ch(1, 48'h1_0000_0000, 48'h2_0000_0040, 3);
      ch_start[1] = 1'b1;
      while (!mem_we && cyc < 40) begin
         step(); cyc++;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_we !== 1'b0 || mem_re !== 1'b0 || ch_busy !== 4'h0) begin
         errors++; $display("FAIL rstmid_async: we=%b re=%b busy=%b, required all 0", mem_we, mem_re, ch_busy);
      end
      step();
      min_lat = 0; max_lat = 0;
      ob = obs_q.size();
      rst_n = 1'b1; tb_ptr = 0;
      exp_q.delete(); add_exp(1, -1);
      wait_pulses(1, 40, "rstmid");
      ch_start[1] = 1'b0; tb_ptr = 2;
      step();
      checks++;
      if (obs_q.size() - ob != exp_q.size()) begin
         errors++; $display("FAIL rstmid_beats: got %0d beats, required %0d", obs_q.size() - ob, exp_q.size());
      end
      foreach (exp_q[k]) if (ob + k < obs_q.size()) begin
         checks++;
         if (obs_q[ob+k] !== exp_q[k]) begin
            errors++; $display("FAIL rstmid_beat%0d: got addr=%h we=%b, required addr=%h we=%b", k,
                               obs_q[ob+k].addr, obs_q[ob+k].we, exp_q[k].addr, exp_q[k].we);
         end
      end
   endtask

   task automatic test_wrap_rearm();
      int ob = obs_q.size(), gb;
      min_lat = 0; max_lat = 0;
      set_ch(2, 48'hFFFF_FFFF_FFF8, 48'h3000, 2);
      exp_q.delete(); add_exp(2, -1);
      ch_start[2] = 1'b1;
      wait_pulses(1, 30, "wrap");
      checks++;
      if (ob + 2 >= obs_q.size() || obs_q[ob+2].addr !== 48'h0 || obs_q[ob+2].we !== 1'b0) begin
         errors++; $display("FAIL wrap_addr: second read not at address 0 (%0d beats logged)", obs_q.size() - ob);
      end
      foreach (exp_q[k]) if (ob + k < obs_q.size()) begin
         checks++;
         if (obs_q[ob+k] !== exp_q[k]) begin
            errors++; $display("FAIL wrap_beat%0d: got addr=%h data=%h, required addr=%h data=%h", k,
                               obs_q[ob+k].addr, obs_q[ob+k].data, exp_q[k].addr, exp_q[k].data);
         end
      end
      gb = grant_q.size();
      repeat (6) step();
      checks++;
      if (grant_q.size() != gb || ch_busy !== 4'h0) begin
         errors++; $display("FAIL rearm_held: %0d re-grants with start held, required 0", grant_q.size() - gb);
      end
      ch_start[2] = 1'b0;
      step();
      ch_start[2] = 1'b1;
      step();
      checks++;
      if (ch_busy !== 4'b0100) begin
         errors++; $display("FAIL rearm_regrant: busy=%b, required 0100", ch_busy);
      end
      wait_pulses(1, 30, "rearm");
      ch_start[2] = 1'b0; tb_ptr = 3;
      step();
   endtask

   task automatic test_random();
      logic [3:0]  mask;
      logic [63:0] r1, r2;
      int          ob, gb;
      min_lat = 0; max_lat = 3;
      repeat (8) begin
         mask = 4'($urandom_range(15, 1));
         for (int c = 0; c < NCHAN; c++) begin
            r1 = {$urandom(), $urandom()};
            r2 = {$urandom(), $urandom()};
            set_ch(c, {r1[47:3], 3'b000}, {r2[47:3], 3'b000}, int'($urandom_range(4, 1)));
         end
         ob = obs_q.size(); gb = grant_q.size();
         rr_model(mask);
         exp_q.delete();
         foreach (ord_q[k]) add_exp(ord_q[k], -1);
         ch_start = mask;
         wait_pulses($countones(mask), 400, "random");
         ch_start = '0;
         step();
         checks++;
         if (obs_q.size() - ob != exp_q.size()) begin
            errors++; $display("FAIL rand_beats: got %0d beats, required %0d", obs_q.size() - ob, exp_q.size());
         end
         foreach (ord_q[k]) if (gb + k < grant_q.size()) begin
            checks++;
            if (grant_q[gb+k] != ord_q[k]) begin
               errors++; $display("FAIL rand_grant%0d: got ch%0d, required ch%0d", k, grant_q[gb+k], ord_q[k]);
            end
         end
         foreach (exp_q[k]) if (ob + k < obs_q.size()) begin
            checks++;
            if (obs_q[ob+k] !== exp_q[k]) begin
               errors++; $display("FAIL rand_beat%0d: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h", k,
                                  obs_q[ob+k].we, obs_q[ob+k].addr, obs_q[ob+k].data,
                                  exp_q[k].we, exp_q[k].addr, exp_q[k].data);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rr_order();
      test_zero_size();
      test_bus_err();
      test_abort();
      test_reset_mid();
      test_wrap_rearm();
      test_random();
      checks++;
      if (overlap != 0) begin
         errors++; $display("FAIL re_we_exclusive: %0d cycles with both set, required 0", overlap);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
